// File: rtl/crypto_wallet_pi_gpio_pkg.sv
// ---------------------------------------------------------------------------
// crypto_wallet_pi_gpio_pkg
// Shared defaults and helpers for the Raspberry Pi GPIO debounce block.
//   DEFAULT_WIDTH           : number of GPIO lines conditioned
//   DEFAULT_SYNC_STAGES     : metastability flop depth
//   DEFAULT_DEBOUNCE_CYCLES : stable-input duration (1 ms at 50 MHz)
//   edge_pair_t             : registered rise/fall strobe pair for one line
//   counter_width()         : width of a counter that must reach 'cycles'
// ---------------------------------------------------------------------------
package crypto_wallet_pi_gpio_pkg;

    localparam int DEFAULT_WIDTH           = 3;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_pair_t;

    // Never returns zero so a degenerate configuration still gives a legal vector.
    function automatic int counter_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/crypto_wallet_pi_gpio_debounce_if.sv
// ---------------------------------------------------------------------------
// crypto_wallet_pi_gpio_debounce_if
// Bundles the pin-side input and the conditioned outputs of the debounce block.
//   gpio_raw   : asynchronous pins from the Pi header
//   gpio_clean : debounced level (feeds the PIO in_port)
//   rise_pulse : one-cycle strobe on a clean 0->1 change
//   fall_pulse : one-cycle strobe on a clean 1->0 change
// Modports:
//   master : the pin/consumer side (drives gpio_raw, observes results)
//   slave  : the debounce block itself
// ---------------------------------------------------------------------------
interface crypto_wallet_pi_gpio_debounce_if
    import crypto_wallet_pi_gpio_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] gpio_raw;
    logic [WIDTH-1:0] gpio_clean;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    modport master (
        output gpio_raw,
        input  gpio_clean,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  gpio_raw,
        output gpio_clean,
        output rise_pulse,
        output fall_pulse
    );

endinterface

// File: rtl/crypto_wallet_pi_gpio_debounce_bit.sv
// ---------------------------------------------------------------------------
// crypto_wallet_pi_gpio_debounce_bit
// Conditions a single GPIO line: synchroniser, optional debounce counter,
// clean level register and registered rise/fall strobes.
// Ports:
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   raw_in    : asynchronous pin
//   clean_out : conditioned level
//   rise_out  : one-cycle strobe, same cycle clean_out turns 1
//   fall_out  : one-cycle strobe, same cycle clean_out turns 0
// Build option:
//   CRYPTO_WALLET_PI_GPIO_DEBOUNCE_EN defined   -> debounce counter built;
//       clean_out follows the synced value only after DEBOUNCE_CYCLES
//       consecutive cycles of disagreement.
//   CRYPTO_WALLET_PI_GPIO_DEBOUNCE_EN undefined -> no counter; clean_out is
//       the synced value registered once and DEBOUNCE_CYCLES is ignored.
// ---------------------------------------------------------------------------
module crypto_wallet_pi_gpio_debounce_bit
    import crypto_wallet_pi_gpio_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_out,
    output logic fall_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   synced;
    logic                   clean_q;
    logic                   clean_d;
    edge_pair_t             edge_q;
    edge_pair_t             edge_d;

    // Shift chain: bit 0 samples the pin, the top bit is the only one used.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
        synced = sync_q[SYNC_STAGES-1];
    end

`ifdef CRYPTO_WALLET_PI_GPIO_DEBOUNCE_EN
    localparam int              CNT_W    = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter holds how many cycles synced has already disagreed with
    // clean; when it reads DEBOUNCE_CYCLES-1 the current cycle completes the
    // run, so the level is accepted on this edge and the count restarts.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (synced == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = synced;
            cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        clean_d = synced;
    end
`endif

    // Strobes are computed from the level about to be registered so they
    // appear in the same cycle as the new clean level.
    always_comb begin
        edge_d.rise = clean_d & ~clean_q;
        edge_d.fall = ~clean_d & clean_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            clean_q <= RESET_VAL;
            edge_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            clean_q <= clean_d;
            edge_q  <= edge_d;
        end
    end

    assign clean_out = clean_q;
    assign rise_out  = edge_q.rise;
    assign fall_out  = edge_q.fall;

endmodule

// File: rtl/crypto_wallet_pi_gpio_debounce.sv
// ---------------------------------------------------------------------------
// crypto_wallet_pi_gpio_debounce
// Conditions WIDTH asynchronous Raspberry Pi GPIO lines into clean,
// synchronous levels plus rise/fall strobes. Every line is handled by its own
// independent crypto_wallet_pi_gpio_debounce_bit instance.
// Ports:
//   clk     : system clock (single domain)
//   reset_n : asynchronous active-low reset
//   gpio_if : slave modport of crypto_wallet_pi_gpio_debounce_if
//             (gpio_raw in; gpio_clean, rise_pulse, fall_pulse out)
// Parameters: WIDTH, SYNC_STAGES (2..4), DEBOUNCE_CYCLES (>=1), RESET_VAL.
// Build option: define CRYPTO_WALLET_PI_GPIO_DEBOUNCE_EN to build the
//   debounce counters; without it each line is synchronised and registered
//   once and DEBOUNCE_CYCLES is ignored.
// ---------------------------------------------------------------------------
module crypto_wallet_pi_gpio_debounce
    import crypto_wallet_pi_gpio_pkg::*;
#(
    parameter int             WIDTH           = DEFAULT_WIDTH,
    parameter int             SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int             DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic                           clk,
    input  logic                           reset_n,
    crypto_wallet_pi_gpio_debounce_if.slave gpio_if
);

    // Reject out-of-range configurations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("crypto_wallet_pi_gpio_debounce: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 1");
    end

    logic [WIDTH-1:0] clean_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        crypto_wallet_pi_gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw_in    (gpio_if.gpio_raw[i]),
            .clean_out (clean_vec[i]),
            .rise_out  (rise_vec[i]),
            .fall_out  (fall_vec[i])
        );
    end

    assign gpio_if.gpio_clean = clean_vec;
    assign gpio_if.rise_pulse = rise_vec;
    assign gpio_if.fall_pulse = fall_vec;

endmodule
